// File: rtl/envelope_follower.sv
// envelope_follower
//   Tracks the magnitude of a signed audio stream and derives a gate from it.
//   The level rises toward the rectified input at a rate set by `a` and falls
//   at a rate set by `r`. Each rate drives a phase accumulator, and the level
//   steps only when that accumulator's carry bit is set. A three-state gate
//   (CLOSED/OPEN/HOLD) with a programmable hold time follows the registered level.
//
// Ports
//   sample_clock  : sole clock, one sample per rising edge
//   rst_n         : asynchronous active-low reset
//   sample        : signed 8-bit audio sample
//   a / r         : attack / release rate (0 freezes that direction)
//   thresh_open   : level >= this opens the gate
//   thresh_close  : level <  this starts closing the gate
//   hold          : hold time in samples
//   level         : registered envelope magnitude, 0..254
//   gate          : registered gate output
//   open_pulse    : one-cycle pulse on each CLOSED->OPEN transition
module envelope_follower #(
  parameter int SAMPLE_CLK_FREQ = 31250
) (
  input  logic              sample_clock,
  input  logic              rst_n,
  input  logic signed [7:0] sample,
  input  logic        [7:0] a,
  input  logic        [7:0] r,
  input  logic        [7:0] thresh_open,
  input  logic        [7:0] thresh_close,
  input  logic        [7:0] hold,
  output logic        [7:0] level,
  output logic              gate,
  output logic              open_pulse
);

  // The sample rate only documents the design; reject nonsensical values.
  if (SAMPLE_CLK_FREQ <= 0) begin : g_freq_invalid
    $error("envelope_follower: SAMPLE_CLK_FREQ must be positive");
  end

  typedef enum logic [1:0] {
    ST_CLOSED = 2'd0,
    ST_OPEN   = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t      r_state;
  logic [7:0]  r_hold_cnt;
  logic [9:0]  r_acc_a;
  logic [10:0] r_acc_r;

  logic [7:0]  w_abs;
  logic [6:0]  w_mag;
  logic [7:0]  w_m;
  logic        w_m_gt;
  logic        w_m_lt;
  logic [7:0]  w_diff_up;
  logic [7:0]  w_step_a;
  logic [8:0]  w_up_sum;
  logic [7:0]  w_level_up;
  logic [7:0]  w_step_r;
  logic [7:0]  w_dn;
  logic [7:0]  w_level_dn;

  // Rectify; -128 has no positive 8-bit twin, so it saturates to 127.
  assign w_abs  = sample[7] ? (~sample + 8'd1) : sample;
  assign w_mag  = (w_abs == 8'd128) ? 7'd127 : w_abs[6:0];
  assign w_m    = {w_mag, 1'b0};
  assign w_m_gt = (w_m > level);
  assign w_m_lt = (w_m < level);

  // Attack step is a quarter of the remaining distance, at least 1, clamped to m.
  assign w_diff_up  = w_m - level;
  assign w_step_a   = ((w_diff_up >> 2) == 8'd0) ? 8'd1 : (w_diff_up >> 2);
  assign w_up_sum   = {1'b0, level} + {1'b0, w_step_a};
  assign w_level_up = (w_up_sum > {1'b0, w_m}) ? w_m : w_up_sum[7:0];

  // Release step is level/32, at least 1. When m < level, level >= 1 and
  // step <= level, so the subtraction cannot wrap in the case where it is used.
  assign w_step_r   = ((level >> 5) == 8'd0) ? 8'd1 : (level >> 5);
  assign w_dn       = level - w_step_r;
  assign w_level_dn = (w_dn < w_m) ? w_m : w_dn;

  always_ff @(posedge sample_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_a <= '0;
      r_acc_r <= '0;
      level   <= '0;
    end else begin
      r_acc_a <= w_m_gt ? ({1'b0, r_acc_a[8:0]} + {2'b00, a}) : 10'd0;
      r_acc_r <= w_m_lt ? ({1'b0, r_acc_r[9:0]} + {3'b000, r}) : 11'd0;
      if (w_m_gt && r_acc_a[9]) begin
        level <= w_level_up;
      end else if (w_m_lt && r_acc_r[10]) begin
        level <= w_level_dn;
      end
    end
  end

  // Gate FSM evaluates the registered level; gate reflects the next state.
  always_ff @(posedge sample_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_CLOSED;
      r_hold_cnt <= '0;
      gate       <= 1'b0;
      open_pulse <= 1'b0;
    end else begin
      open_pulse <= 1'b0;
      case (r_state)
        ST_CLOSED: begin
          if (level >= thresh_open) begin
            r_state    <= ST_OPEN;
            gate       <= 1'b1;
            open_pulse <= 1'b1;
          end else begin
            gate <= 1'b0;
          end
        end
        ST_OPEN: begin
          gate <= 1'b1;
          if (level < thresh_close) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= hold;
          end
        end
        ST_HOLD: begin
          // Retrigger wins over hold expiry and does not pulse.
          if (level >= thresh_open) begin
            r_state <= ST_OPEN;
            gate    <= 1'b1;
          end else if (r_hold_cnt == 8'd0) begin
            r_state <= ST_CLOSED;
            gate    <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt - 8'd1;
            gate       <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_CLOSED;
          gate    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_envelope_follower.sv
module tb_envelope_follower;

  logic              sample_clock = 1'b0;
  logic              rst_n;
  logic signed [7:0] sample;
  logic        [7:0] a, r, thresh_open, thresh_close, hold;
  logic        [7:0] level;
  logic              gate, open_pulse;

  envelope_follower #(.SAMPLE_CLK_FREQ(31250)) dut (
    .sample_clock (sample_clock),
    .rst_n        (rst_n),
    .sample       (sample),
    .a            (a),
    .r            (r),
    .thresh_open  (thresh_open),
    .thresh_close (thresh_close),
    .hold         (hold),
    .level        (level),
    .gate         (gate),
    .open_pulse   (open_pulse)
  );

  always #5 sample_clock = ~sample_clock;

  int total = 0;
  int bad   = 0;

  // Reference model: envelope as an integer, rate accumulators as plain
  // counters that tick on reaching their overflow value, gate as an
  // "is open" flag plus remaining hold samples (-1 = not holding).
  int m_lvl, m_acc_a, m_acc_r, m_hold_left;
  bit m_gate, m_pulse;

  typedef struct {
    int smp; int aa; int rr; int to; int tc; int hd; int n;
    int exp_lvl; int exp_gate;
  } vec_t;
  vec_t vt[8];

  int prev, pulses, hcnt, ph;
  bit seen, pend;

  function automatic int mag2(int s);
    int v;
    v = (s < 0) ? -s : s;
    if (v > 127) v = 127;
    return 2 * v;
  endfunction

  function automatic int imin(int x, int y); return (x < y) ? x : y; endfunction
  function automatic int imax(int x, int y); return (x > y) ? x : y; endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lvl = 0; m_acc_a = 0; m_acc_r = 0;
    m_hold_left = -1; m_gate = 0; m_pulse = 0;
  endtask

  task automatic model_step();
    int m, old;
    bit tk;
    m   = mag2(int'(sample));
    old = m_lvl;
    if (m > old) begin
      tk = (m_acc_a >= 512);
      m_acc_a = (m_acc_a % 512) + int'(a);
      if (tk) m_lvl = imin(old + imax((m - old) / 4, 1), m);
    end else begin
      m_acc_a = 0;
    end
    if (m < old) begin
      tk = (m_acc_r >= 1024);
      m_acc_r = (m_acc_r % 1024) + int'(r);
      if (tk) m_lvl = imax(old - imax(old / 32, 1), m);
    end else begin
      m_acc_r = 0;
    end
    m_pulse = 0;
    if (!m_gate) begin
      if (old >= int'(thresh_open)) begin
        m_gate = 1; m_pulse = 1; m_hold_left = -1;
      end
    end else if (m_hold_left < 0) begin
      if (old < int'(thresh_close)) m_hold_left = int'(hold);
    end else begin
      if (old >= int'(thresh_open)) m_hold_left = -1;
      else if (m_hold_left == 0) begin m_gate = 0; m_hold_left = -1; end
      else m_hold_left--;
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge sample_clock);
    #1;
    chk("level", int'(level), m_lvl);
    chk("gate", int'(gate), int'(m_gate));
    chk("open_pulse", int'(open_pulse), int'(m_pulse));
  endtask

  task automatic set_in(int s, int aa, int rr, int to, int tc, int hd);
    sample = 8'(s); a = 8'(aa); r = 8'(rr);
    thresh_open = 8'(to); thresh_close = 8'(tc); hold = 8'(hd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //         smp  a    r    to  tc   hd  n    lvl  gate
    vt[0] = '{   0,   0,   0, 64,  32, 10, 100,   0, 0};
    vt[1] = '{-128, 255,   0, 64,  32, 10, 200, 254, 1};
    vt[2] = '{   0, 255, 255, 64,  32, 10, 700,   0, 0};
    vt[3] = '{ 100,   0,   0, 64,  32, 10,  50,   0, 0};
    vt[4] = '{ 100, 255,   0, 64,  32, 10, 200, 200, 1};
    vt[5] = '{ 127, 255,   0, 64,  32, 10, 100, 254, 1};
    vt[6] = '{  -1, 255, 255, 64,  32, 10, 800,   2, 0};
    vt[7] = '{  40, 255, 255, 64, 100,  0, 100,  80, 1};

    rst_n = 1'b0;
    set_in(0, 0, 0, 64, 32, 10);
    #12;
    chk("rst_level", int'(level), 0);
    chk("rst_gate", int'(gate), 0);
    chk("rst_pulse", int'(open_pulse), 0);
    #1 rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 8; i++) begin
      set_in(vt[i].smp, vt[i].aa, vt[i].rr, vt[i].to, vt[i].tc, vt[i].hd);
      for (int k = 0; k < vt[i].n; k++) cyc();
      chk($sformatf("vec%0d_level", i), int'(level), vt[i].exp_lvl);
      chk($sformatf("vec%0d_gate", i), int'(gate), vt[i].exp_gate);
    end

    // Asynchronous reset between edges in the middle of an attack.
    set_in(-128, 255, 0, 64, 32, 10);
    for (int k = 0; k < 6; k++) cyc();
    for (int k = 0; k < 6; k++) cyc();
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_level", int'(level), 0);
    chk("async_rst_gate", int'(gate), 0);
    chk("async_rst_pulse", int'(open_pulse), 0);
    @(posedge sample_clock);
    #1;
    chk("held_rst_level", int'(level), 0);
    #2 rst_n = 1'b1;
    model_reset();

    // Fresh attack to full scale: monotonic, one open pulse, gate one cycle late.
    prev = int'(level); seen = 0; pend = 0; pulses = 0;
    for (int i = 0; i < 300; i++) begin
      cyc();
      chk("attack_monotonic", int'(int'(level) >= prev), 1);
      chk("attack_max", int'(level <= 8'd254), 1);
      if (open_pulse) pulses++;
      if (pend) begin chk("gate_one_after", int'(gate), 1); pend = 0; end
      if (!seen && level >= 8'd64) begin
        seen = 1; pend = 1;
        chk("gate_not_yet", int'(gate), 0);
      end
      prev = int'(level);
      if (seen && !pend && level == 8'd254) break;
    end
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (open_pulse) pulses++;
      chk("settle_254", int'(level), 254);
    end
    chk("attack_pulses", pulses, 1);

    // Release to zero with hold=10: gate high 11 cycles once in HOLD.
    set_in(0, 255, 255, 64, 32, 10);
    prev = int'(level); ph = 0; hcnt = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      chk("release_monotonic", int'(int'(level) <= prev), 1);
      prev = int'(level);
      if (ph == 1) begin
        if (gate) hcnt++;
        else ph = 2;
      end
      if (ph == 0 && level < 8'd32) ph = 1;
      if (ph == 2 && level == 8'd0) break;
    end
    chk("hold_cycles", hcnt, 11);
    chk("release_zero", int'(level), 0);

    // Retrigger from HOLD: gate never drops and no pulse.
    set_in(-128, 255, 255, 250, 240, 50);
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (level == 8'd254 && gate) break;
    end
    chk("retrig_open", int'(gate), 1);
    sample = 8'sd0;
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      cyc();
      chk("retrig_gate_fall", int'(gate), 1);
      if (open_pulse) pulses++;
      if (level < 8'd240) break;
    end
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk("retrig_gate_hold", int'(gate), 1);
      if (open_pulse) pulses++;
    end
    sample = 8'sd127;
    for (int k = 0; k < 100; k++) begin
      cyc();
      chk("retrig_gate_rise", int'(gate), 1);
      if (open_pulse) pulses++;
    end
    chk("retrig_pulses", pulses, 0);
    chk("retrig_level", int'(level), 254);

    // Random segments, with occasional single-input changes mid-segment.
    for (int s = 0; s < 50; s++) begin
      set_in(int'($urandom_range(0, 255)) - 128,
             ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255)),
             ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 15)));
      for (int k = 0; k < int'($urandom_range(1, 60)); k++) begin
        case ($urandom_range(0, 9))
          0: sample = 8'($urandom_range(0, 255));
          1: thresh_open = 8'($urandom_range(0, 255));
          2: thresh_close = 8'($urandom_range(0, 255));
          3: hold = 8'($urandom_range(0, 7));
          default: ;
        endcase
        cyc();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/envelope_follower.md
ENVELOPE_FOLLOWER -- requirements
Module: envelope_follower

Interface
REQ-001 The block SHALL have one parameter: SAMPLE_CLK_FREQ, default 31250, sample rate in Hz (informational only, no effect on logic).
REQ-002 The block SHALL have these ports:
- sample_clock  in  1  sole clock; one audio sample per rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sample  in  8  signed two's-complement audio sample.
- a  in  8  attack rate; 0 freezes rise.
- r  in  8  release rate; 0 freezes fall.
- thresh_open  in  8  level at or above which the gate opens.
- thresh_close  in  8  level below which the gate starts closing.
- hold  in  8  hold time, in samples.
- level  out  8  tracked envelope magnitude, registered.
- gate  out  1  gate output, registered.
- open_pulse  out  1  one-cycle pulse on each CLOSED->OPEN transition.

Function
REQ-003 Rectify sample combinationally: mag = |sample|; -128 SHALL saturate to 127; m = mag*2 (range 0..254).
REQ-004 Attack accumulator acc_a (10 bit) SHALL load acc_a[8:0]+a each cycle while m>level, and SHALL clear to 0 otherwise.
REQ-005 Release accumulator acc_r (11 bit) SHALL load acc_r[9:0]+r each cycle while m<level, and SHALL clear to 0 otherwise.
REQ-006 Attack tick: when registered acc_a[9]=1 and m>level, then level <= min(level+step_a, m), where step_a = max((m-level)>>2, 1).
REQ-007 Release tick: when registered acc_r[10]=1 and m<level, then level <= max(level-step_r, m), where step_r = max(level>>5, 1).
REQ-008 level SHALL never overshoot m in either direction, SHALL never wrap, and SHALL stay 0..254.
REQ-009 When m==level, level and both accumulators SHALL hold/clear per REQ-004 and REQ-005; there SHALL be no tick.
REQ-010 The gate FSM SHALL have states CLOSED, OPEN and HOLD, plus an 8-bit hold_cnt, and SHALL evaluate the registered level.
- CLOSED: if level>=thresh_open, go to OPEN.
- OPEN: if level<thresh_close, go to HOLD and set hold_cnt<=hold.
- HOLD: if level>=thresh_open, go to OPEN (retrigger has priority). Otherwise, if hold_cnt==0, go to CLOSED. Otherwise hold_cnt decrements.
REQ-011 gate SHALL be 1 exactly when the next state is OPEN or HOLD, registered on the same edge as the state.
REQ-012 open_pulse SHALL be high for exactly the one cycle following each CLOSED->OPEN edge; HOLD->OPEN SHALL NOT pulse.
REQ-013 With hold=0, HOLD SHALL last exactly one cycle; with hold=N and no retrigger, gate SHALL stay high N+1 cycles after entering HOLD.
REQ-014 If thresh_close>thresh_open, the block SHALL still follow REQ-010 literally, with no special handling.
REQ-015 Gate response latency: the gate reacts one cycle after the level it evaluates has been registered.
REQ-016 Inputs a, r, thresh_open, thresh_close and hold MAY change on any cycle and SHALL take effect on the next edge.

Reset
REQ-017 While rst_n=0, asynchronously: level=0, gate=0, open_pulse=0, state=CLOSED, acc_a=0, acc_r=0, hold_cnt=0.
REQ-018 Reset asserted mid-attack, mid-release or in HOLD SHALL abort immediately to the REQ-017 values.
REQ-019 The first update after rst_n rises SHALL occur on the first following sample_clock edge.

Verification
REQ-020 Reset, then sample=0 for 100 cycles -> level=0, gate=0, open_pulse never high.
REQ-021 sample=-128, a=255, thresh_open=64:
- level rises monotonically and settles at exactly 254, never exceeding it.
- gate rises on the first cycle after level>=64.
- open_pulse fires exactly once.
REQ-022 From level=254, gate open: sample=0, r=255, thresh_close=32, hold=10:
- level falls monotonically to 0.
- gate stays 1 for exactly 11 cycles after entering HOLD, then goes 0.
REQ-023 During HOLD, drive sample=127 so that level>=thresh_open -> state returns to OPEN, gate never drops, and no open_pulse.
REQ-024 sample=100 with a=0 -> level stays 0. Setting a=255 then lets level reach exactly 200 with no overshoot.
REQ-025 Assert rst_n=0 asynchronously between edges during attack -> all outputs go to the REQ-017 values at once. After release, behaviour matches a fresh start.
